// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem result path: the result entry carried
// through the CSR FIFO and the output register.
package fpu_ss_pkg;

    localparam int unsigned FPU_SS_ID_WIDTH       = 4;
    localparam int unsigned FPU_SS_CSR_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [FPU_SS_ID_WIDTH-1:0] id;
        logic [4:0]                 rd;
        logic [31:0]                data;
        logic                       we;
    } fpu_ss_result_t;

endpackage

// File: rtl/fpu_ss_result_fifo.sv
// Small synchronous FIFO of result entries. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is ignored.
module fpu_ss_result_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = FPU_SS_CSR_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  fpu_ss_result_t         data_i,
    input  logic                   pop_i,
    output fpu_ss_result_t         data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    fpu_ss_result_t   mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fpu_ss_result_arb.sv
// Result stage merging buffered CSR writebacks and FPU results into the
// core's single offload result channel; FP-destination results also write
// the FP register file in the handshake cycle.
module fpu_ss_result_arb
    import fpu_ss_pkg::*;
#(
    parameter int unsigned CSR_FIFO_DEPTH = FPU_SS_CSR_FIFO_DEPTH,
    parameter int unsigned ID_WIDTH       = FPU_SS_ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                csr_wb_i,
    input  logic [31:0]         csr_rdata_i,
    input  logic [4:0]          csr_wb_addr_i,
    input  logic [ID_WIDTH-1:0] csr_wb_id_i,
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [31:0]         fpu_result_i,
    input  logic [4:0]          fpu_rd_i,
    input  logic [ID_WIDTH-1:0] fpu_id_i,
    input  logic                fpu_we_int_i,
    output logic                fpr_we_o,
    output logic [4:0]          fpr_waddr_o,
    output logic [31:0]         fpr_wdata_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                csr_stall_o,
    output logic                csr_overflow_o
);

    localparam int unsigned CNT_W = $clog2(CSR_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(CSR_FIFO_DEPTH - 1);

    fpu_ss_result_t   csr_entry, fifo_head;
    fpu_ss_result_t   or_q, or_d;
    logic             or_valid_q, or_valid_d;
    logic             overflow_q, overflow_d;
    logic             or_free, fifo_pop, fifo_full, fifo_empty, fpu_hs;
    logic [CNT_W-1:0] fifo_count;

    assign csr_entry = '{id: csr_wb_id_i, rd: csr_wb_addr_i, data: csr_rdata_i, we: 1'b1};

    fpu_ss_result_fifo #(
        .DEPTH (CSR_FIFO_DEPTH)
    ) u_csr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (csr_wb_i),
        .data_i  (csr_entry),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Both channels use valid/ready: a transfer happens in a cycle where valid
    // and ready are high together, and a raised valid holds its payload
    // unchanged until that transfer. Ready never depends on the partner's valid.
    assign or_free     = !or_valid_q || result_ready_i;
    assign fifo_pop    = or_free && !fifo_empty;
    assign fpu_ready_o = or_free && fifo_empty;
    assign fpu_hs      = fpu_valid_i && fpu_ready_o;

    assign fpr_we_o    = fpu_hs && !fpu_we_int_i;
    assign fpr_waddr_o = fpr_we_o ? fpu_rd_i : 5'd0;
    assign fpr_wdata_o = fpr_we_o ? fpu_result_i : 32'd0;

    assign csr_stall_o = (fifo_count >= STALL_CNT);

    always_comb begin
        or_valid_d = or_valid_q;
        or_d       = or_q;
        overflow_d = overflow_q || (csr_wb_i && fifo_full && !fifo_pop);
        if (or_free) begin
            if (!fifo_empty) begin
                or_valid_d = 1'b1;
                or_d       = fifo_head;
                or_d.we    = 1'b1;
            end else if (fpu_hs) begin
                or_valid_d = 1'b1;
                or_d.id    = fpu_id_i;
                or_d.rd    = fpu_rd_i;
                or_d.we    = fpu_we_int_i;
                or_d.data  = fpu_we_int_i ? fpu_result_i : 32'd0;
            end else begin
                or_valid_d = 1'b0;
                or_d       = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            or_valid_q <= 1'b0;
            or_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_q       <= or_d;
            overflow_q <= overflow_d;
        end
    end

    assign result_valid_o = or_valid_q;
    assign result_id_o    = or_q.id;
    assign result_rd_o    = or_q.rd;
    assign result_data_o  = or_q.data;
    assign result_we_o    = or_q.we;
    assign csr_overflow_o = overflow_q;

endmodule
